// File: rtl/wts_envelope_generator_if.sv
// wts_envelope_generator_if
//   Groups the envelope generator's control and output signals.
//   master : register block / tick source side (drives triggers, rates,
//            tick; observes envelope and env_busy)
//   slave  : envelope generator side
//   Signals:
//     envelope_tick  1-cycle strobe that advances envelope timing
//     key_on/key_off 1-cycle attack / release triggers
//     reg_ar/dr/sl/rr 4-bit attack, decay, sustain level, release rate
//     envelope       9-bit level 0..256 (256 = full scale)
//     env_busy       envelope not idle
interface wts_envelope_generator_if;
   logic       envelope_tick;
   logic       key_on;
   logic       key_off;
   logic [3:0] reg_ar;
   logic [3:0] reg_dr;
   logic [3:0] reg_sl;
   logic [3:0] reg_rr;
   logic [8:0] envelope;
   logic       env_busy;

   modport master (
      output envelope_tick, key_on, key_off, reg_ar, reg_dr, reg_sl, reg_rr,
      input  envelope, env_busy
   );

   modport slave (
      input  envelope_tick, key_on, key_off, reg_ar, reg_dr, reg_sl, reg_rr,
      output envelope, env_busy
   );
endinterface

// File: rtl/wts_envelope_generator.sv
// wts_envelope_generator
//   Per-channel linear ADSR envelope feeding the channel volume stage.
//   Level runs 0..256; 256 means the wave passes through unscaled.
//   Timing advances only on envelope_tick; key triggers act every clock.
//   Ports:
//     clk     system clock
//     nreset  asynchronous reset, active low
//     bus     wts_envelope_generator_if.slave (triggers, rate registers,
//             tick in; envelope and env_busy out)
//   Parameter:
//     PERIOD_SHIFT  step period = (15 - rate) << PERIOD_SHIFT ticks (0..4)
module wts_envelope_generator #(
   parameter int unsigned PERIOD_SHIFT = 2
) (
   input  logic                         clk,
   input  logic                         nreset,
   wts_envelope_generator_if.slave      bus
);

   localparam int unsigned CW = 4 + PERIOD_SHIFT;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ATTACK  = 3'd1;
   localparam logic [2:0] ST_DECAY   = 3'd2;
   localparam logic [2:0] ST_SUSTAIN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam logic [8:0] LEVEL_MAX = 9'd256;

   logic [2:0]    state, state_n;
   logic [8:0]    level, level_n;
   logic [CW-1:0] cnt, cnt_n;

   logic [3:0]    rate;
   logic [CW-1:0] period;
   logic [8:0]    target;
   logic          step;

   // Rate of the active phase; IDLE and SUSTAIN have none (treated as 0).
   always_comb begin
      rate = 4'd0;
      case (state)
         ST_ATTACK:  rate = bus.reg_ar;
         ST_DECAY:   rate = bus.reg_dr;
         ST_RELEASE: rate = bus.reg_rr;
         default:    rate = 4'd0;
      endcase
   end

   assign period = CW'(4'd15 - rate) << PERIOD_SHIFT;
   assign target = (bus.reg_sl == 4'hF) ? LEVEL_MAX : {1'b0, bus.reg_sl, 4'b0000};
   assign step   = (cnt == period);

   always_comb begin
      state_n = state;
      level_n = level;
      cnt_n   = cnt;
      if (bus.key_on) begin
         state_n = ST_ATTACK;
         cnt_n   = '0;
      end else if (bus.key_off &&
                   (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
         state_n = ST_RELEASE;
         cnt_n   = '0;
      end else if (bus.envelope_tick && rate != 4'd0) begin
         // Each phase first checks whether its goal already holds, so a
         // phase entered at (or past) its target leaves on the first tick
         // without stepping.
         case (state)
            ST_ATTACK: begin
               if (level >= LEVEL_MAX) begin
                  state_n = ST_DECAY;
                  cnt_n   = '0;
               end else if (rate == 4'd15) begin
                  level_n = LEVEL_MAX;
                  state_n = ST_DECAY;
                  cnt_n   = '0;
               end else if (step) begin
                  level_n = level + 9'd1;
                  cnt_n   = '0;
                  if (level == LEVEL_MAX - 9'd1)
                     state_n = ST_DECAY;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_DECAY: begin
               if (level <= target) begin
                  state_n = ST_SUSTAIN;
               end else if (rate == 4'd15) begin
                  level_n = target;
                  state_n = ST_SUSTAIN;
               end else if (step) begin
                  level_n = level - 9'd1;
                  cnt_n   = '0;
                  if ((level - 9'd1) <= target)
                     state_n = ST_SUSTAIN;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (level == 9'd0) begin
                  state_n = ST_IDLE;
               end else if (rate == 4'd15) begin
                  level_n = 9'd0;
                  state_n = ST_IDLE;
               end else if (step) begin
                  level_n = level - 9'd1;
                  cnt_n   = '0;
                  if (level == 9'd1)
                     state_n = ST_IDLE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= ST_IDLE;
         level <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         level <= level_n;
         cnt   <= cnt_n;
      end
   end

   assign bus.envelope = level;
   assign bus.env_busy = (state != ST_IDLE);

endmodule

// File: doc/wts_envelope_generator.md
Name: wts_envelope_generator

Overview:
- Per-channel linear ADSR envelope generator; sits directly upstream of the channel volume stage.
- Drives its 9-bit envelope input: 0..255 scale the wave; 256 (bit 8 set) means full scale, i.e. the wave passes through unscaled.
- Steps once per envelope_tick strobe at register-selected rates and follows key on/off triggers from the register block.

Parameters:
PERIOD_SHIFT, 2, left shift applied to the inverted rate to form the step period in ticks (valid 0..4)

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous reset, active low (negative logic)
envelope_tick  input  1  one-cycle strobe; all envelope timing advances only on cycles where it is 1
key_on  input  1  one-cycle trigger: start attack
key_off  input  1  one-cycle trigger: start release
reg_ar  input  4  attack rate
reg_dr  input  4  decay rate
reg_sl  input  4  sustain level
reg_rr  input  4  release rate
envelope  output  9  registered level 0..256; bit 8 set only at exactly 256
env_busy  output  1  1 when state is not IDLE

Behaviour:
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Reset (async, nreset=0): state IDLE, level 0, step counter 0, envelope=0, env_busy=0.
  - A reset mid-envelope aborts immediately; there is no ramp-down.
- Triggers are sampled on every clock, independent of envelope_tick:
  - key_on (any state): state becomes ATTACK, step counter becomes 0, level is retained (no restart from 0).
  - key_off in ATTACK/DECAY/SUSTAIN: state becomes RELEASE, counter becomes 0, level retained.
  - key_off in IDLE or RELEASE: ignored.
  - key_on and key_off in the same cycle: key_on wins.
- Active rate: ATTACK uses reg_ar, DECAY uses reg_dr, RELEASE uses reg_rr. IDLE and SUSTAIN have no rate.
- Step period: p = (15 - rate) << PERIOD_SHIFT. The counter is (4+PERIOD_SHIFT) bits wide.
- Rate 0: level frozen and the state is held. The counter does not advance.
- Rate 15: the level jumps to the state target on the next tick.
- Rate 1..14: on each tick, if counter == p, take one step and clear the counter; otherwise increment the counter. One step therefore occurs every p+1 ticks.
- Step rules:
  - ATTACK: level +1. On reaching 256, go to DECAY and clear the counter.
  - DECAY: target T = reg_sl==15 ? 256 : {reg_sl,4'b0000}. Level -1 per step. When level <= T, go to SUSTAIN.
    - If level <= T already holds on the first tick in DECAY (e.g. reg_sl=15), go to SUSTAIN on that tick with no step.
  - SUSTAIN: hold level until key_off. reg_sl changes while in SUSTAIN do not move the level.
  - RELEASE: level -1 per step. On reaching 0, go to IDLE.
- Level never exceeds 256 and never goes below 0; the arithmetic saturates.
- Timing:
  - envelope is a register equal to the internal level.
  - A level change caused by a tick at cycle n is visible on envelope at cycle n+1.
  - env_busy follows state with the same 1-cycle latency.
- Register writes to rate registers take effect at the next tick; the counter is not cleared.
  - If a new p is below the current counter value, the counter wraps naturally through its full width before stepping. This is accepted behaviour.

Test Plan:
- Reset mid-ATTACK at level 100 -> envelope=0 and env_busy=0 asynchronously; no tick is needed.
- reg_ar=15, reg_dr=0, key_on, 1 tick -> envelope=256. Next tick -> state DECAY; level frozen at 256 (rate 0).
- PERIOD_SHIFT=2, reg_ar=14 (p=4), key_on from 0 -> envelope increments once every 5 ticks; after 1280 ticks, envelope=256 and state is DECAY.
- reg_ar=15, reg_dr=15, reg_sl=8 -> 256 after tick 1, 128 after tick 2, then SUSTAIN. 1000 further ticks -> still 128. key_off with reg_rr=15 -> 0 on the next tick, then IDLE with env_busy=0.
- In SUSTAIN at 128: key_on and key_off in the same cycle -> ATTACK from 128, no release. With reg_ar=15 -> 256 on the next tick.
- key_off in IDLE -> no change (envelope=0, env_busy=0). reg_sl=15 -> DECAY passes straight to SUSTAIN at 256.
